// File: rtl/background_pixel_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : background_pixel_fetch_if
// Description : Pixel-coordinate, ROM and colour-output bundle for
//               background_pixel_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
interface background_pixel_fetch_if;
    logic        frame_start;
    logic [2:0]  scroll_step;
    logic        pix_valid;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [14:0] read_address;
    logic        rom_data;
    logic        rgb_valid;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;

    modport master (
        output frame_start, scroll_step, pix_valid, DrawX, DrawY, rom_data,
        input  read_address, rgb_valid, Red, Green, Blue
    );

    modport slave (
        input  frame_start, scroll_step, pix_valid, DrawX, DrawY, rom_data,
        output read_address, rgb_valid, Red, Green, Blue
    );
endinterface
`default_nettype wire

// File: rtl/background_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : background_pixel_fetch
// Description : Three-stage background fetch: window test and ROM address,
//               ROM wait, colour select. Horizontal scroll when BG_SCROLL_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module background_pixel_fetch #(
    parameter int          ORIGIN_X    = 192,
    parameter int          ORIGIN_Y    = 112,
    parameter int          SCALE_SHIFT = 1,
    parameter logic [23:0] FG_RGB      = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB      = 24'h000000,
    parameter logic [23:0] BORDER_RGB  = 24'h202040
) (
    input  wire logic               Clk,
    input  wire logic               Reset,
    background_pixel_fetch_if.slave bus
);

    localparam int         c_X_END    = ORIGIN_X + 256;
    localparam int         c_Y_END    = ORIGIN_Y + 256;
    localparam logic [9:0] c_ORIGIN_X = ORIGIN_X[9:0];
    localparam logic [9:0] c_ORIGIN_Y = ORIGIN_Y[9:0];

    logic        w_in_win;
    logic [6:0]  w_u;
    logic [6:0]  w_v;
    logic [6:0]  w_col;
    logic [6:0]  w_scroll_x;
    logic [14:0] w_addr;

    logic [14:0] r_read_address;
    logic        r_valid1;
    logic        r_win1;
    logic        r_valid2;
    logic        r_win2;
    logic        r_rgb_valid;
    logic [23:0] r_rgb;

    // Compare in 32-bit signed space so the window end never wraps.
    assign w_in_win = (int'(bus.DrawX) >= ORIGIN_X) && (int'(bus.DrawX) < c_X_END) &&
                      (int'(bus.DrawY) >= ORIGIN_Y) && (int'(bus.DrawY) < c_Y_END);

    assign w_u    = 7'((bus.DrawX - c_ORIGIN_X) >> SCALE_SHIFT);
    assign w_v    = 7'((bus.DrawY - c_ORIGIN_Y) >> SCALE_SHIFT);
    assign w_col  = w_u + w_scroll_x;
    assign w_addr = {1'b0, w_v, w_col};

`ifdef BG_SCROLL_EN
    logic [6:0] r_scroll_x;

    // A pixel sampled on the frame_start edge still sees the old scroll.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_scroll_x <= 7'd0;
        end else if (bus.frame_start) begin
            r_scroll_x <= r_scroll_x + {4'd0, bus.scroll_step};
        end
    end

    assign w_scroll_x = r_scroll_x;
`else
    logic w_unused_scroll;

    assign w_scroll_x      = 7'd0;
    assign w_unused_scroll = bus.frame_start ^ (^bus.scroll_step);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_read_address <= 15'd0;
            r_valid1       <= 1'b0;
            r_win1         <= 1'b0;
        end else begin
            r_valid1 <= bus.pix_valid;
            r_win1   <= w_in_win;
            if (bus.pix_valid && w_in_win) begin
                r_read_address <= w_addr;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid2 <= 1'b0;
            r_win2   <= 1'b0;
        end else begin
            r_valid2 <= r_valid1;
            r_win2   <= r_win1;
        end
    end

    // Colour holds through bubbles so the outputs stay stable.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rgb_valid <= 1'b0;
            r_rgb       <= 24'd0;
        end else begin
            r_rgb_valid <= r_valid2;
            if (r_valid2) begin
                r_rgb <= r_win2 ? (bus.rom_data ? FG_RGB : BG_RGB) : BORDER_RGB;
            end
        end
    end

    assign bus.read_address = r_read_address;
    assign bus.rgb_valid    = r_rgb_valid;
    assign bus.Red          = r_rgb[23:16];
    assign bus.Green        = r_rgb[15:8];
    assign bus.Blue         = r_rgb[7:0];

endmodule
`default_nettype wire

// File: tb/tb_background_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_background_pixel_fetch
// Description : Randomised self-checking bench for background_pixel_fetch
//               against a queue-based pixel model and a synchronous ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_background_pixel_fetch;

    localparam int          c_OX     = 192;
    localparam int          c_OY     = 112;
    localparam int          c_SH     = 1;
    localparam logic [23:0] c_FG     = 24'hFFFFFF;
    localparam logic [23:0] c_BG     = 24'h000000;
    localparam logic [23:0] c_BORDER = 24'h202040;

    typedef struct {
        bit          v;
        logic [23:0] rgb;
    } rec_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    background_pixel_fetch_if u_bus ();

    background_pixel_fetch #(
        .ORIGIN_X    (c_OX),
        .ORIGIN_Y    (c_OY),
        .SCALE_SHIFT (c_SH),
        .FG_RGB      (c_FG),
        .BG_RGB      (c_BG),
        .BORDER_RGB  (c_BORDER)
    ) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (u_bus)
    );

    always #5 Clk = ~Clk;

    bit rom [32768];

    always @(posedge Clk) u_bus.rom_data <= rom[u_bus.read_address];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_scroll = 0;
    int          m_addr   = 0;
    bit          m_valid  = 0;
    logic [23:0] m_rgb    = 24'd0;
    rec_t        pipe[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dut_rgb();
        return {u_bus.Red, u_bus.Green, u_bus.Blue};
    endfunction

    // One clock: drive at negedge, advance the model, compare after posedge.
    task automatic step(input bit rst, input bit fs, input logic [2:0] ss,
                        input bit pv, input int x, input int y);
        rec_t r;
        bit   inw;
        int   u, v, a;
        @(negedge Clk);
        Reset             = rst;
        u_bus.frame_start = fs;
        u_bus.scroll_step = ss;
        u_bus.pix_valid   = pv;
        u_bus.DrawX       = 10'(x);
        u_bus.DrawY       = 10'(y);
        inw = (x >= c_OX) && (x < c_OX + 256) && (y >= c_OY) && (y < c_OY + 256);
        a = 0;
        if (inw) begin
            u = ((x - c_OX) >> c_SH) % 128;
            v = ((y - c_OY) >> c_SH) % 128;
            a = v * 128 + (u + m_scroll) % 128;
        end
        @(posedge Clk);
        #1;
        if (rst) begin
            m_addr   = 0;
            m_scroll = 0;
            m_valid  = 0;
            m_rgb    = 24'd0;
            pipe     = {};
            r.v      = 0;
            r.rgb    = 24'd0;
            pipe.push_back(r);
            pipe.push_back(r);
        end else begin
            if (pv && inw) m_addr = a;
            r.v   = pv;
            r.rgb = inw ? (rom[a] ? c_FG : c_BG) : c_BORDER;
            pipe.push_back(r);
            r = pipe.pop_front();
            m_valid = r.v;
            if (r.v) m_rgb = r.rgb;
`ifdef BG_SCROLL_EN
            if (fs) m_scroll = (m_scroll + int'(ss)) % 128;
`endif
        end
        check("read_address", 32'(u_bus.read_address), 32'(m_addr));
        check("rgb_valid", 32'(u_bus.rgb_valid), 32'(m_valid));
        if (rst || m_valid) check("rgb", 32'(dut_rgb()), 32'(m_rgb));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) rom[i] = bit'($urandom_range(0, 1));
        u_bus.frame_start = 0;
        u_bus.scroll_step = 3'd0;
        u_bus.pix_valid   = 0;
        u_bus.DrawX       = 10'd0;
        u_bus.DrawY       = 10'd0;

        // Reset state and first pixel at the window origin.
        step(1, 0, 3'd0, 0, 0, 0);
        step(1, 0, 3'd0, 0, 0, 0);
        check("reset_rgb_valid", 32'(u_bus.rgb_valid), 32'd0);
        check("reset_rgb", 32'(dut_rgb()), 32'd0);
        step(0, 0, 3'd0, 1, 192, 112);
        check("origin_addr", 32'(u_bus.read_address), 32'd0);
        idle(2);
        check("origin_valid", 32'(u_bus.rgb_valid), 32'd1);
        check("origin_rgb", 32'(dut_rgb()), rom[0] ? 32'(c_FG) : 32'(c_BG));

        // Bottom-right corner, then one column outside the window.
        step(0, 0, 3'd0, 1, 447, 367);
        check("corner_addr", 32'(u_bus.read_address), 32'd16383);
        step(0, 0, 3'd0, 1, 448, 367);
        check("outside_addr_hold", 32'(u_bus.read_address), 32'd16383);
        idle(2);
        check("outside_valid", 32'(u_bus.rgb_valid), 32'd1);
        check("outside_rgb", 32'(dut_rgb()), 32'h202040);

        // Streaming with alternating pix_valid.
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 3'd0, (i % 2) == 0, 192 + i, 112);
            if ((i % 2) == 0) check("stream_addr", 32'(u_bus.read_address), 32'(i / 2));
        end
        idle(2);

`ifdef BG_SCROLL_EN
        step(1, 0, 3'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 3'd1, 0, 0, 0);
        step(0, 0, 3'd0, 1, 444, 114);
        check("scroll3_addr", 32'(u_bus.read_address), 32'd129);
        idle(2);

        step(1, 0, 3'd0, 0, 0, 0);
        step(0, 1, 3'd5, 0, 0, 0);
        step(0, 1, 3'd2, 1, 192, 112);
        check("fs_same_edge_addr", 32'(u_bus.read_address), 32'd5);
        step(0, 0, 3'd0, 1, 194, 112);
        check("fs_next_addr", 32'(u_bus.read_address), 32'd8);
        idle(2);
`endif

        // Reset while three pixels are in flight.
        step(1, 0, 3'd0, 0, 0, 0);
        step(0, 0, 3'd0, 1, 200, 120);
        step(0, 0, 3'd0, 1, 202, 120);
        step(0, 0, 3'd0, 1, 204, 120);
        step(1, 1, 3'd7, 1, 206, 120);
        check("midreset_valid", 32'(u_bus.rgb_valid), 32'd0);
        check("midreset_rgb", 32'(dut_rgb()), 32'd0);
        check("midreset_addr", 32'(u_bus.read_address), 32'd0);
        idle(1);
        check("midreset_flush1", 32'(u_bus.rgb_valid), 32'd0);
        idle(1);
        check("midreset_flush2", 32'(u_bus.rgb_valid), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int x, y;
            bit rst, fs, pv;
            if ($urandom_range(0, 9) == 0) begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end else begin
                x = $urandom_range(150, 480);
                y = $urandom_range(80, 400);
            end
            rst = ($urandom_range(0, 199) == 0);
            fs  = ($urandom_range(0, 15) == 0);
            pv  = ($urandom_range(0, 3) != 0);
            step(rst, fs, 3'($urandom_range(0, 7)), pv, x, y);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
